// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: issues word reads to a synchronous code ROM, buffers the
// returned instructions in a small FIFO and hands them to decode over valid/ready.
module inst_fetch_unit #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    input  logic                  rom_illegal_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic                  inst_fault_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
    logic                  inflight_reg, inflight_next;
    logic [ADDR_WIDTH-1:0] inflight_pc_reg, inflight_pc_next;
    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]      count_reg, count_next;

    logic [DATA_WIDTH-1:0] inst_mem  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
    logic                  fault_mem [FIFO_DEPTH];

    logic                  pop;
    logic                  push;
    logic                  issue_en;
    logic [CNT_W-1:0]      count_after_pop;
    logic [CNT_W-1:0]      credit_used;

    assign rom_addr_o   = fetch_pc_reg;
    assign inst_valid_o = (count_reg != '0);

    // A redirect cancels the handshake and any response, so neither pop nor push may fire with it.
    assign pop  = inst_valid_o & inst_ready_i & ~redirect_i;
    assign push = inflight_reg & ~redirect_i & (state_reg == ST_RUN);

    // Credit counts the in-flight read as an already-reserved slot so a push can never overflow.
    assign count_after_pop = count_reg - CNT_W'(pop);
    assign credit_used     = count_after_pop + CNT_W'(inflight_reg);
    assign issue_en        = (state_reg == ST_RUN) & ~redirect_i &
                             (credit_used < CNT_W'(FIFO_DEPTH));

    always_comb begin
        state_next       = state_reg;
        fetch_pc_next    = fetch_pc_reg;
        inflight_next    = 1'b0;
        inflight_pc_next = inflight_pc_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        count_next       = count_reg;

        if (redirect_i) begin
            state_next    = ST_RUN;
            fetch_pc_next = redirect_pc_i;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
        end else begin
            if (push && rom_illegal_i) begin
                state_next = ST_FAULT;
            end
            if (issue_en) begin
                inflight_next    = 1'b1;
                inflight_pc_next = fetch_pc_reg;
                fetch_pc_next    = fetch_pc_reg + ADDR_WIDTH'(4);
            end
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            count_next = count_after_pop + CNT_W'(push);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_RUN;
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            fetch_pc_reg    <= fetch_pc_next;
            inflight_reg    <= inflight_next;
            inflight_pc_reg <= inflight_pc_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
        end
    end

    // Entry storage needs no reset: the occupancy count alone decides what is visible.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    inst_mem[gi]  <= rom_illegal_i ? '0 : rom_data_i;
                    pc_mem[gi]    <= inflight_pc_reg;
                    fault_mem[gi] <= rom_illegal_i;
                end
            end
        end
    endgenerate

    assign inst_o       = inst_valid_o ? inst_mem[rd_ptr_reg]  : '0;
    assign inst_pc_o    = inst_valid_o ? pc_mem[rd_ptr_reg]    : '0;
    assign inst_fault_o = inst_valid_o ? fault_mem[rd_ptr_reg] : 1'b0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a behavioural ROM, an expected-instruction queue filled
// whenever a fetch stream is started, and a monitor that pops and compares accepted heads.
module tb_inst_fetch_unit;

    localparam int AW = 64;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
        logic          fault;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          rom_illegal;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          inst_fault;

    int   test_cnt = 0;
    int   fail_cnt = 0;
    int   pop_cnt  = 0;
    exp_t exp_q[$];

    inst_fetch_unit #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RESET_PC  (64'h0),
        .FIFO_DEPTH(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .rom_illegal_i(rom_illegal),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .inst_valid_o (inst_valid),
        .inst_ready_i (inst_ready),
        .inst_o       (inst),
        .inst_pc_o    (inst_pc),
        .inst_fault_o (inst_fault)
    );

    always #5 clk = ~clk;

    // ROM contents: word i holds i+0x100; any non-word-aligned address is illegal.
    always @(posedge clk) begin
        rom_data    <= 32'((rom_addr >> 2) + 64'h100);
        rom_illegal <= (rom_addr[1:0] != 2'b00);
    end

    function automatic exp_t mk_exp(input logic [AW-1:0] a);
        exp_t e;
        e.pc    = a;
        e.fault = (a[1:0] != 2'b00);
        e.inst  = e.fault ? 32'h0 : 32'((a >> 2) + 64'h100);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] req);
        test_cnt++;
        assert (obs === req) else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic start_stream(input logic [AW-1:0] start);
        logic [AW-1:0] a;
        exp_t          e;
        exp_q.delete();
        a = start;
        for (int i = 0; i < 64; i++) begin
            e = mk_exp(a);
            exp_q.push_back(e);
            if (e.fault) break;
            a = a + 64'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Redirect, then check the documented latency: valid low for two cycles, target head after the third edge.
    task automatic do_redirect(input logic [AW-1:0] target);
        exp_t e;
        e           = mk_exp(target);
        redirect    = 1'b1;
        redirect_pc = target;
        start_stream(target);
        tick();
        redirect   = 1'b0;
        inst_ready = 1'b1;
        chk("redir_valid_c1", 64'(inst_valid), 64'd0);
        tick();
        chk("redir_valid_c2", 64'(inst_valid), 64'd0);
        tick();
        chk("redir_valid_c3", 64'(inst_valid), 64'd1);
        chk("redir_head_pc", inst_pc, e.pc);
        chk("redir_head_inst", 64'(inst), 64'(e.inst));
        chk("redir_head_fault", 64'(inst_fault), 64'(e.fault));
    endtask

    // Scoreboard: every accepted head must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && !redirect && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop_pc", inst_pc, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                pop_cnt++;
                $display("[TB] pop pc=%0h inst=%0h fault=%0b", inst_pc, inst, inst_fault);
                chk("pop_pc", inst_pc, e.pc);
                chk("pop_inst", 64'(inst), 64'(e.inst));
                chk("pop_fault", 64'(inst_fault), 64'(e.fault));
            end
        end
    end

    initial begin
        #100000;
        fail_cnt++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            pops_before;
        logic [AW-1:0] held_pc;

        rst_n       = 1'b1;
        inst_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_pc", inst_pc, 64'd0);
        chk("rst_fault", 64'(inst_fault), 64'd0);
        chk("rst_rom_addr", rom_addr, 64'd0);

        // 1: sequential stream from RESET_PC, one instruction per cycle
        start_stream(64'h0);
        rst_n = 1'b1;
        tick();
        chk("t1_valid_edge1", 64'(inst_valid), 64'd0);
        tick();
        chk("t1_valid_edge2", 64'(inst_valid), 64'd1);
        chk("t1_first_pc", inst_pc, 64'h0);
        chk("t1_first_inst", 64'(inst), 64'h100);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t1_no_bubble", 64'(inst_valid), 64'd1);
        end

        // 2: decode stalls for 5 cycles
        inst_ready  = 1'b0;
        held_pc     = exp_q[0].pc;
        pops_before = pop_cnt;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_stall_valid", 64'(inst_valid), 64'd1);
            chk("t2_stall_head_pc", inst_pc, held_pc);
        end
        chk("t2_fetch_held", rom_addr, held_pc + 64'd8);
        chk("t2_no_pops", 64'(pop_cnt), 64'(pops_before));
        inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("t2_resumed_pops", 64'(pop_cnt), 64'(pops_before + 6));

        // 3: redirect while the buffer is full
        inst_ready = 1'b0;
        tick();
        tick();
        do_redirect(64'h40);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stream_valid", 64'(inst_valid), 64'd1);
        end

        // 4: misaligned redirect produces a single fault entry, then silence
        do_redirect(64'h42);
        for (int i = 0; i < 8; i++) tick();
        chk("t4_no_more_valid", 64'(inst_valid), 64'd0);
        chk("t4_queue_drained", 64'(exp_q.size()), 64'd0);
        do_redirect(64'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_resume_valid", 64'(inst_valid), 64'd1);
        end

        // 5: redirect near the top of the address space, wrapping to 0
        do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_wrap_valid", 64'(inst_valid), 64'd1);
        end

        // 6: reset pulse mid-stream
        chk("t6_pre_valid", 64'(inst_valid), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_rst_valid", 64'(inst_valid), 64'd0);
        chk("t6_rst_inst", 64'(inst), 64'd0);
        chk("t6_rst_pc", inst_pc, 64'd0);
        chk("t6_rst_fault", 64'(inst_fault), 64'd0);
        chk("t6_rst_rom_addr", rom_addr, 64'd0);
        tick();
        rst_n = 1'b1;
        start_stream(64'h0);
        tick();
        chk("t6_valid_edge1", 64'(inst_valid), 64'd0);
        tick();
        chk("t6_valid_edge2", 64'(inst_valid), 64'd1);
        chk("t6_first_pc", inst_pc, 64'h0);
        for (int i = 0; i < 5; i++) tick();

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
